// File: rtl/fb_mem_target.sv
// Frame-buffer memory target: answers read/write burst requests on the shared command bus
// and holds {8'h0, R, G, B} pixel words in an internal word array.
module fb_mem_target #(
  parameter int          DEPTH   = 256,
  parameter int          AW      = 8,
  parameter logic [3:0]  INIT_ID = 4'h1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic [31:0] addrdatain,
  input  logic        ackin,
  output logic [1:0]  reqout,
  output logic [3:0]  reqtar,
  output logic [2:0]  cmdout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout,
  output logic        busy
);

  localparam logic [2:0] CMD_IDLE    = 3'b000;
  localparam logic [2:0] CMD_WR_DATA = 3'b001;
  localparam logic [2:0] CMD_RD_REQ  = 3'b010;
  localparam logic [2:0] CMD_RD_DATA = 3'b011;
  localparam logic [2:0] CMD_WR_REQ  = 3'b100;
  localparam logic [2:0] CMD_WR_RESP = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_BID, S_RD_DATA, S_WR_BID, S_WR_RESP, S_WR_DATA
  } state_t;

  function automatic logic [3:0] burst_beats(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

  logic [31:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    len_q, len_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    reqout_q, reqout_d;
  logic [3:0]    reqtar_q, reqtar_d;
  logic [2:0]    cmdout_q, cmdout_d;
  logic [1:0]    lenout_q, lenout_d;
  logic [31:0]   data_q, data_d;
  logic          busy_q, busy_d;
  logic          wr_en;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    reqout_d = reqout_q;
    reqtar_d = reqtar_q;
    cmdout_d = cmdout_q;
    lenout_d = lenout_q;
    data_d   = data_q;
    wr_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (selin && (cmdin == CMD_RD_REQ || cmdin == CMD_WR_REQ)) begin
          idx_d    = addrdatain[AW+1:2];
          len_d    = lenin;
          cnt_d    = 4'd0;
          reqout_d = 2'b01;
          reqtar_d = INIT_ID;
          state_d  = (cmdin == CMD_RD_REQ) ? S_RD_BID : S_WR_BID;
        end
      end
      S_RD_BID, S_RD_DATA: begin
        // A grant launches the first beat; each beat cycle either launches the next or closes the burst.
        if (state_q == S_RD_DATA && cnt_q == burst_beats(len_q)) begin
          state_d  = S_IDLE;
          cmdout_d = CMD_IDLE;
          lenout_d = 2'b00;
          data_d   = 32'd0;
          reqout_d = 2'b00;
          reqtar_d = 4'd0;
        end else if (state_q == S_RD_DATA || ackin) begin
          state_d  = S_RD_DATA;
          cmdout_d = CMD_RD_DATA;
          lenout_d = len_q;
          data_d   = mem[idx_q];
          idx_d    = idx_q + 1'b1;
          cnt_d    = cnt_q + 4'd1;
        end
      end
      S_WR_BID: begin
        if (ackin) begin
          state_d  = S_WR_RESP;
          cmdout_d = CMD_WR_RESP;
        end
      end
      S_WR_RESP: begin
        state_d  = S_WR_DATA;
        cmdout_d = CMD_IDLE;
        reqout_d = 2'b00;
        reqtar_d = 4'd0;
      end
      S_WR_DATA: begin
        if (selin && cmdin == CMD_WR_DATA) begin
          wr_en = 1'b1;
          idx_d = idx_q + 1'b1;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == burst_beats(len_q)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= 2'b00;
      cnt_q    <= 4'd0;
      reqout_q <= 2'b00;
      reqtar_q <= 4'd0;
      cmdout_q <= CMD_IDLE;
      lenout_q <= 2'b00;
      data_q   <= 32'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      reqout_q <= reqout_d;
      reqtar_q <= reqtar_d;
      cmdout_q <= cmdout_d;
      lenout_q <= lenout_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx_q] <= addrdatain;
  end

  assign reqout      = reqout_q;
  assign reqtar      = reqtar_q;
  assign cmdout      = cmdout_q;
  assign lenout      = lenout_q;
  assign addrdataout = data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fb_mem_target.sv
// Bench for fb_mem_target: directed bus transactions, expected responses queued
// by the stimulus and checked by an independent output monitor.
module tb_fb_mem_target;

  localparam logic [3:0] INIT_ID = 4'h1;

  logic        clk;
  logic        reset_n;
  logic        selin;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;
  logic        ackin;
  logic [1:0]  reqout;
  logic [3:0]  reqtar;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [36:0] exp_q [$];
  logic [31:0] vec [8];

  fb_mem_target #(.DEPTH(256), .AW(8), .INIT_ID(INIT_ID)) dut (
    .clk(clk), .reset_n(reset_n), .selin(selin), .cmdin(cmdin), .lenin(lenin),
    .addrdatain(addrdatain), .ackin(ackin), .reqout(reqout), .reqtar(reqtar),
    .cmdout(cmdout), .lenout(lenout), .addrdataout(addrdataout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n && cmdout !== 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'({cmdout, lenout, addrdataout}), 64'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("resp", 64'({cmdout, lenout, addrdataout}), 64'(e));
      end
    end
  end

  task automatic idle_inputs();
    selin = 1'b0; cmdin = 3'b000; addrdatain = 32'd0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] len, input int stall_after);
    int n;
    n = 1 << len;
    selin = 1'b1; cmdin = 3'b100; lenin = len; addrdatain = addr;
    tick();
    idle_inputs();
    chk("wr_bid_req", 64'(reqout), 64'h1);
    chk("wr_bid_busy", 64'(busy), 64'h1);
    exp_q.push_back({3'b101, 2'b00, 32'd0});
    ackin = 1'b1;
    tick();
    ackin = 1'b0;
    tick();
    chk("wr_data_req_off", 64'(reqout), 64'h0);
    for (int i = 0; i < n; i++) begin
      selin = 1'b1; cmdin = 3'b001; addrdatain = vec[i];
      tick();
      if (i + 1 == stall_after) begin
        selin = 1'b1; cmdin = 3'b000; addrdatain = 32'hDEADBEEF;
        tick();
      end
    end
    idle_inputs();
    chk("wr_busy_drop", 64'(busy), 64'h0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] len, input int ack_dly,
                         input int inject);
    int n;
    n = 1 << len;
    for (int i = 0; i < n; i++) exp_q.push_back({3'b011, len, vec[i]});
    selin = 1'b1; cmdin = 3'b010; lenin = len; addrdatain = addr;
    tick();
    idle_inputs();
    chk("rd_bid_req", 64'(reqout), 64'h1);
    chk("rd_bid_tar", 64'(reqtar), 64'(INIT_ID));
    repeat (ack_dly) tick();
    ackin = 1'b1;
    tick();
    ackin = 1'b0;
    for (int b = 1; b <= n; b++) begin
      chk("rd_beat_req", 64'(reqout), 64'h1);
      chk("rd_beat_busy", 64'(busy), 64'h1);
      if (b == inject) begin
        selin = 1'b1; cmdin = 3'b010; lenin = 2'b11; addrdatain = 32'h0;
      end
      tick();
      idle_inputs();
    end
    chk("rd_end_req", 64'(reqout), 64'h0);
    chk("rd_end_tar", 64'(reqtar), 64'h0);
    chk("rd_end_cmd", 64'(cmdout), 64'h0);
    chk("rd_end_busy", 64'(busy), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; ackin = 1'b0; lenin = 2'b00;
    idle_inputs();
    #12;
    chk("rst_reqout", 64'(reqout), 64'h0);
    chk("rst_reqtar", 64'(reqtar), 64'h0);
    chk("rst_cmdout", 64'(cmdout), 64'h0);
    chk("rst_lenout", 64'(lenout), 64'h0);
    chk("rst_data", 64'(addrdataout), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    #10 reset_n = 1'b1;
    tick(); tick();
    chk("idle_busy", 64'(busy), 64'h0);
    chk("idle_reqout", 64'(reqout), 64'h0);

    // Deselected request must not bid.
    selin = 1'b0; cmdin = 3'b010; addrdatain = 32'h48;
    tick(); tick();
    chk("nosel_reqout", 64'(reqout), 64'h0);
    chk("nosel_busy", 64'(busy), 64'h0);
    idle_inputs();
    tick();

    vec[0] = 32'h00112233; vec[1] = 32'h00445566;
    vec[2] = 32'h00778899; vec[3] = 32'h00AABBCC;
    do_write(32'h48, 2'b10, 0);
    do_read(32'h48, 2'b10, 2, 0);

    // Wrapping write with a stall between beats 2 and 3.
    vec[0] = 32'h00A1B2C3; vec[1] = 32'h00D4E5F6;
    vec[2] = 32'h00010203; vec[3] = 32'h00040506;
    do_write(32'h3F8, 2'b10, 2);
    do_read(32'h3F8, 2'b10, 0, 0);
    vec[0] = 32'h00010203; vec[1] = 32'h00040506;
    do_read(32'h0, 2'b01, 1, 0);
    vec[0] = 32'h00D4E5F6; vec[1] = 32'h00010203;
    do_read(32'h3FC, 2'b01, 0, 0);

    // Request during a burst is dropped.
    vec[0] = 32'h00112233; vec[1] = 32'h00445566;
    vec[2] = 32'h00778899; vec[3] = 32'h00AABBCC;
    do_read(32'h48, 2'b10, 1, 2);
    tick(); tick(); tick();
    chk("ignored_req_reqout", 64'(reqout), 64'h0);
    chk("ignored_req_busy", 64'(busy), 64'h0);

    // Reset during beat 2 of an 8-beat read.
    exp_q.push_back({3'b011, 2'b11, 32'h00112233});
    selin = 1'b1; cmdin = 3'b010; lenin = 2'b11; addrdatain = 32'h48;
    tick();
    idle_inputs();
    ackin = 1'b1;
    tick();
    ackin = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("abort_cmdout", 64'(cmdout), 64'h0);
    chk("abort_reqout", 64'(reqout), 64'h0);
    chk("abort_data", 64'(addrdataout), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    #2 reset_n = 1'b1;
    tick(); tick();
    chk("post_abort_cmdout", 64'(cmdout), 64'h0);
    vec[0] = 32'h00112233;
    do_read(32'hFFFFF04B, 2'b00, 0, 0);

    tick(); tick();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fb_mem_target.md
Name: fb_mem_target

Overview:
- Frame-buffer memory target on the shared command bus; the responder end of the video controller's pixel-fetch read bursts.
- Decodes read requests (cmd 010) and write requests (cmd 100).
- Bids the arbiter, then returns burst read data (cmd 011) or a write response (cmd 101) followed by write data capture (cmd 001).
- Holds pixel words {8'h0, R, G, B} in an internal synchronous word array.

Parameters:
- DEPTH, 256, number of 32-bit words in the frame-buffer array (power of 2).
- AW, 8, word-index width; equals log2(DEPTH).
- INIT_ID, 4'h1, value driven on reqtar during a bid (bus port of the initiator being answered).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- selin  in  1  bus select; cmdin and addrdatain are valid for this block only when high
- cmdin  in  3  bus command: 000 idle, 001 write data, 010 read req, 011 read data, 100 write req, 101 write resp
- lenin  in  2  burst length code: 00=1, 01=2, 10=4, 11=8 beats
- addrdatain  in  32  byte address in request phase; write data in data phase
- ackin  in  1  arbiter grant for this block's bid
- reqout  out  2  arbiter bid; 00 none, 01 normal
- reqtar  out  4  bid target; INIT_ID while bidding, else 0
- cmdout  out  3  response command
- lenout  out  2  echoes latched burst length code during read data beats
- addrdataout  out  32  read data
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: clk rising edge; reset_n asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, beat counter 0. Array contents are not reset. Reset mid-burst aborts immediately, with no further beats.
- All outputs are registered.
- Address decode: word index = addrdatain[AW+1:2]. Bits [1:0] and the bits above AW+1 are ignored. The index increments by 1 per beat and wraps modulo DEPTH.
- Burst length: N = 1 << lenin, latched with the address on the request cycle.
- IDLE state:
  - selin && cmdin==010 → latch index and length, go to RD_BID.
  - selin && cmdin==100 → latch index and length, go to WR_BID.
  - Any other command is ignored.
- RD_BID state:
  - reqout=01, reqtar=INIT_ID; hold until ackin==1.
  - On ackin, go to RD_DATA; the first beat is on the next cycle.
  - Bid appears 1 cycle after the request cycle.
- RD_DATA state:
  - Each cycle: cmdout=011, lenout=latched code, addrdataout=mem[index]; index++, count++.
  - reqout stays 01 for the whole burst.
  - After beat N: cmdout, addrdataout, reqout and reqtar return to 0 on the next cycle; go to IDLE.
  - Beats are back-to-back with no stall.
- WR_BID state: same as RD_BID; on ackin, go to WR_RESP.
- WR_RESP state: cmdout=101 for exactly 1 cycle, reqout→00, go to WR_DATA.
- WR_DATA state:
  - Each cycle with selin && cmdin==001: mem[index] ← addrdatain, index++, count++.
  - Cycles with any other cmdin stall (no write, no count).
  - After the N-th write, go to IDLE; busy drops the following cycle.
- Requests arriving while busy are ignored, not queued. The initiator must wait for busy==0.
- Read-during-write: not possible; the block handles one transaction at a time.
- Simultaneous events: ackin in the same cycle the bid first asserts is accepted. ackin outside a BID state is ignored.

Test Plan:
- Reset with reset_n=0 → all outputs 0 and busy=0. Release → stays IDLE with cmdin=000.
- Preload mem[0x12..0x15] = 0x00112233, 0x00445566, 0x00778899, 0x00AABBCC. Read req addr 0x48, lenin=10, ackin 2 cycles after bid → 4 consecutive beats, cmdout=011, lenout=10, data in order. reqout=00 after the last beat.
- Write req addr 0x3F8 (DEPTH=256, index 0xFE), lenin=10; send 4 data beats with one cmd 000 stall between beats 2 and 3 → writes land at 0xFE, 0xFF, 0x00, 0x01. Read-back returns the same data (wrap verified).
- Read req issued while a read burst is in progress → ignored. Only the original burst is returned; busy stays high until it completes.
- reset_n asserted during beat 2 of an 8-beat read → outputs 0 immediately. A new 1-beat read after release returns the correct single word.
- selin=0 with cmdin=010 → no bid; reqout stays 00.
